// File: rtl/um_pkt_pkg.sv
// Shared definitions for the UM packet path: flit layout, header codes and
// the transmit FSM state type.
package um_pkt_pkg;

    localparam int unsigned FLIT_W = 134;
    localparam int unsigned HDR_HI = 133;
    localparam int unsigned HDR_LO = 132;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_SEND    = 2'd2,
        ST_DISCARD = 2'd3
    } tx_state_t;

    function automatic logic is_tail(input logic [FLIT_W-1:0] flit);
        return flit[HDR_HI:HDR_LO] == HDR_TAIL;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (first word one cycle after rd).
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [0:(1 << AW)-1];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                rdata  <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/pkt_tx_buf.sv
// Buffers producer packets and replays whole good packets to the UM input.
// Define PKT_TX_STAT_EN to add the tx_pkt_cnt / drop_pkt_cnt statistics ports.
module pkt_tx_buf
    import um_pkt_pkg::*;
#(
    parameter int unsigned DATA_AW       = 8,
    parameter int unsigned VALID_AW      = 6,
    parameter int unsigned MAX_PKT_FLITS = 96
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] src_data,
    input  logic              src_data_wr,
    input  logic              src_data_valid,
    input  logic              src_data_valid_wr,
    output logic              src_data_ready,
    output logic [FLIT_W-1:0] pktin_data,
    output logic              pktin_data_wr,
    output logic              pktin_data_valid,
    output logic              pktin_data_valid_wr,
    input  logic              pktin_data_ready,
    output logic              ovf_err
`ifdef PKT_TX_STAT_EN
    ,
    output logic [63:0]       tx_pkt_cnt,
    output logic [63:0]       drop_pkt_cnt
`endif
);

    localparam logic [DATA_AW:0]  D_DEPTH   = (DATA_AW+1)'(1 << DATA_AW);
    localparam logic [DATA_AW:0]  MAX_FLITS = (DATA_AW+1)'(MAX_PKT_FLITS);
    localparam logic [VALID_AW:0] V_DEPTH   = (VALID_AW+1)'(1 << VALID_AW);

    logic [FLIT_W-1:0] d_rdata;
    logic              d_rd;
    logic              d_full;
    logic              d_empty;
    logic [DATA_AW:0]  d_count;
    logic [DATA_AW:0]  d_free;

    logic              v_wdata;
    logic              v_rdata;
    logic              v_rd;
    logic              v_full;
    logic              v_empty;
    logic [VALID_AW:0] v_count;

    logic              flit_drop;
    logic              drop_flag;
    logic              pop_pkt;
    logic              tail_now;
    logic              emit;
    tx_state_t         state;
    tx_state_t         state_nxt;

    // A tail dropped in the same cycle as valid_wr must also mark the packet bad.
    assign flit_drop = src_data_wr && d_full;
    assign v_wdata   = src_data_valid && !drop_flag && !flit_drop;
    assign d_free    = D_DEPTH - d_count;
    assign pop_pkt   = !v_empty && pktin_data_ready;
    assign tail_now  = is_tail(d_rdata);

    sync_fifo #(
        .WIDTH (FLIT_W),
        .AW    (DATA_AW)
    ) u_data_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (src_data_wr),
        .wdata (src_data),
        .rd    (d_rd),
        .rdata (d_rdata),
        .full  (d_full),
        .empty (d_empty),
        .count (d_count)
    );

    sync_fifo #(
        .WIDTH (1),
        .AW    (VALID_AW)
    ) u_valid_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (src_data_valid_wr),
        .wdata (v_wdata),
        .rd    (v_rd),
        .rdata (v_rdata),
        .full  (v_full),
        .empty (v_empty),
        .count (v_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_flag      <= 1'b0;
            ovf_err        <= 1'b0;
            src_data_ready <= 1'b0;
        end else begin
            if (src_data_valid_wr) begin
                drop_flag <= 1'b0;
            end else if (flit_drop) begin
                drop_flag <= 1'b1;
            end
            if (flit_drop || (src_data_valid_wr && v_full)) begin
                ovf_err <= 1'b1;
            end
            src_data_ready <= (d_free >= MAX_FLITS) && (v_count != V_DEPTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (pop_pkt) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tail_now) begin
                    state_nxt = ST_IDLE;
                end else if (v_rdata) begin
                    state_nxt = ST_SEND;
                end else begin
                    state_nxt = ST_DISCARD;
                end
            end
            ST_SEND, ST_DISCARD: begin
                if (tail_now) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // d_rdata always holds the flit popped last cycle; it is registered onto
    // the UM bus while the next flit is fetched, so the tail leaves in IDLE.
    always_comb begin
        v_rd = 1'b0;
        d_rd = 1'b0;
        emit = 1'b0;
        unique case (state)
            ST_IDLE: begin
                v_rd = pop_pkt;
                d_rd = pop_pkt;
            end
            ST_START: begin
                emit = v_rdata;
                d_rd = !tail_now && !d_empty;
            end
            ST_SEND: begin
                emit = 1'b1;
                d_rd = !tail_now && !d_empty;
            end
            ST_DISCARD: begin
                d_rd = !tail_now && !d_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pktin_data          <= '0;
            pktin_data_wr       <= 1'b0;
            pktin_data_valid    <= 1'b0;
            pktin_data_valid_wr <= 1'b0;
        end else begin
            pktin_data_wr       <= emit;
            pktin_data_valid    <= emit && tail_now;
            pktin_data_valid_wr <= emit && tail_now;
            if (emit) begin
                pktin_data <= d_rdata;
            end
        end
    end

`ifdef PKT_TX_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pkt_cnt   <= '0;
            drop_pkt_cnt <= '0;
        end else begin
            if (pktin_data_valid_wr && (tx_pkt_cnt != '1)) begin
                tx_pkt_cnt <= tx_pkt_cnt + 64'd1;
            end
            if ((state == ST_START) && !v_rdata && (drop_pkt_cnt != '1)) begin
                drop_pkt_cnt <= drop_pkt_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_tx_buf.sv
// Scoreboard bench for pkt_tx_buf: good packets are queued as expected flits,
// an independent negedge monitor pops and compares whatever the DUT emits.
`timescale 1ns/1ps
module tb_pkt_tx_buf;
    import um_pkt_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLIT_W-1:0] src_data;
    logic              src_data_wr;
    logic              src_data_valid;
    logic              src_data_valid_wr;
    logic              src_data_ready;
    logic [FLIT_W-1:0] pktin_data;
    logic              pktin_data_wr;
    logic              pktin_data_valid;
    logic              pktin_data_valid_wr;
    logic              pktin_data_ready;
    logic              ovf_err;
`ifdef PKT_TX_STAT_EN
    logic [63:0]       tx_pkt_cnt;
    logic [63:0]       drop_pkt_cnt;
    logic [63:0]       tx0;
    logic [63:0]       dr0;
`endif

    logic man_rdy;
    logic rand_rdy;
    logic rand_on;
    assign pktin_data_ready = rand_on ? rand_rdy : man_rdy;

    int                checks;
    int                errors;
    int unsigned       cyc = 0;
    int unsigned       vwr_cyc;
    int unsigned       flits_out = 0;
    int unsigned       pkts_out = 0;
    int unsigned       vwr_total = 0;
    logic [FLIT_W-1:0] exp_q[$];
    int unsigned       head_q[$];
    int unsigned       tail_q[$];
    logic              in_pkt = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_on) rand_rdy = ($urandom_range(0, 3) != 0);
    end

    pkt_tx_buf #(
        .DATA_AW       (8),
        .VALID_AW      (6),
        .MAX_PKT_FLITS (96)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .src_data            (src_data),
        .src_data_wr         (src_data_wr),
        .src_data_valid      (src_data_valid),
        .src_data_valid_wr   (src_data_valid_wr),
        .src_data_ready      (src_data_ready),
        .pktin_data          (pktin_data),
        .pktin_data_wr       (pktin_data_wr),
        .pktin_data_valid    (pktin_data_valid),
        .pktin_data_valid_wr (pktin_data_valid_wr),
        .pktin_data_ready    (pktin_data_ready),
        .ovf_err             (ovf_err)
`ifdef PKT_TX_STAT_EN
        ,
        .tx_pkt_cnt          (tx_pkt_cnt),
        .drop_pkt_cnt        (drop_pkt_cnt)
`endif
    );

    // Monitor: every emitted flit must be the next expected one, packets
    // must be contiguous, and valid/valid_wr must mark exactly the tail.
    always @(negedge clk) begin
        logic [FLIT_W-1:0] e;
        logic              is_t;
        if (!rst_n) begin
            in_pkt = 1'b0;
        end else if (pktin_data_wr) begin
            is_t = (pktin_data[133:132] == 2'b10);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_flit: got %h expected none", pktin_data);
            end else begin
                e = exp_q.pop_front();
                if (pktin_data !== e) begin
                    errors++;
                    $display("FAIL flit_data: got %h expected %h", pktin_data, e);
                end
            end
            checks++;
            if (pktin_data_valid_wr !== is_t || pktin_data_valid !== is_t) begin
                errors++;
                $display("FAIL tail_strobes: got valid_wr=%b valid=%b expected %b",
                         pktin_data_valid_wr, pktin_data_valid, is_t);
            end
            if (pktin_data[133:132] == 2'b01) head_q.push_back(cyc);
            if (is_t) begin
                tail_q.push_back(cyc);
                pkts_out++;
            end
            if (pktin_data_valid_wr) vwr_total++;
            flits_out++;
            in_pkt = !is_t;
        end else begin
            checks++;
            if (in_pkt) begin
                errors++;
                $display("FAIL contiguous: got wr=0 mid-packet expected wr=1");
            end
            checks++;
            if (pktin_data_valid_wr !== 1'b0 || pktin_data_valid !== 1'b0) begin
                errors++;
                $display("FAIL stray_strobe: got valid_wr=%b valid=%b expected 0",
                         pktin_data_valid_wr, pktin_data_valid);
            end
            if (pktin_data_valid_wr) vwr_total++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] h);
        return {h, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic write_flit(input logic [FLIT_W-1:0] f, input logic last, input logic good);
        @(posedge clk);
        #1;
        src_data          = f;
        src_data_wr       = 1'b1;
        src_data_valid_wr = last;
        src_data_valid    = last & good;
        if (last) vwr_cyc = cyc;
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        src_data_wr       = 1'b0;
        src_data_valid_wr = 1'b0;
        src_data_valid    = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic good, input logic expect_out);
        logic [FLIT_W-1:0] f;
        for (int i = 0; i < n; i++) begin
            f = mk((i == 0) ? HDR_HEAD : (i == n - 1) ? HDR_TAIL : HDR_BODY);
            if (good && expect_out) exp_q.push_back(f);
            write_flit(f, i == n - 1, good);
        end
        idle_in();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending flits expected 0", name, exp_q.size());
        end
        repeat (5) step();
    endtask

    task automatic wait_src_ready(input string name);
        int n = 0;
        while (!src_data_ready && n < 2000) begin
            step();
            n++;
        end
        chk(name, 64'(src_data_ready), 64'd1);
    endtask

    task automatic wait_flits(input string name, input int unsigned target, input int budget);
        int n = 0;
        while (flits_out < target && n < budget) begin
            step();
            n++;
        end
        chk(name, 64'(flits_out >= target), 64'd1);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        int unsigned base_pk;
        int unsigned base_vwr;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        src_data = '0;
        src_data_wr = 1'b0;
        src_data_valid = 1'b0;
        src_data_valid_wr = 1'b0;
        man_rdy = 1'b0;
        rand_rdy = 1'b0;
        rand_on = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_ready", 64'(src_data_ready), 64'd0);
        chk("rst_pktin_wr", 64'(pktin_data_wr), 64'd0);
        chk("rst_pktin_valid", 64'(pktin_data_valid), 64'd0);
        chk("rst_pktin_valid_wr", 64'(pktin_data_valid_wr), 64'd0);
        chk("rst_pktin_data_zero", 64'(pktin_data == '0), 64'd1);
        chk("rst_ovf_err", 64'(ovf_err), 64'd0);
        rst_n = 1'b1;
        chk("ready_before_first_edge", 64'(src_data_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_release", 64'(src_data_ready), 64'd1);

        // Plan 1: one good 4-flit packet, latency counted from the valid_wr sampling edge.
        man_rdy = 1'b1;
        base_pk = pkts_out;
        head_q.delete();
        send_pkt(4, 1'b1, 1'b1);
        drain("t1", 100);
        chk("t1_pkts", 64'(pkts_out - base_pk), 64'd1);
        chk("t1_heads", 64'(head_q.size()), 64'd1);
        if (head_q.size() == 1)
            chk("t1_latency", 64'(head_q[0] - (vwr_cyc + 1)), 64'd2);

        // Plan 2: bad packet discarded, following good packet delivered.
`ifdef PKT_TX_STAT_EN
        tx0 = tx_pkt_cnt;
        dr0 = drop_pkt_cnt;
`endif
        base_pk = pkts_out;
        send_pkt(3, 1'b0, 1'b1);
        send_pkt(2, 1'b1, 1'b1);
        drain("t2", 100);
        chk("t2_pkts", 64'(pkts_out - base_pk), 64'd1);
`ifdef PKT_TX_STAT_EN
        chk("t2_drop_cnt", drop_pkt_cnt - dr0, 64'd1);
        chk("t2_tx_cnt", tx_pkt_cnt - tx0, 64'd1);
`endif

        // Plan 3: five buffered packets released together, one idle cycle between each.
        man_rdy = 1'b0;
        base = flits_out;
        for (int k = 0; k < 5; k++) send_pkt(int'($urandom_range(2, 6)), 1'b1, 1'b1);
        repeat (20) step();
        chk("t3_no_output_while_low", 64'(flits_out - base), 64'd0);
        head_q.delete();
        tail_q.delete();
        man_rdy = 1'b1;
        drain("t3", 200);
        chk("t3_heads", 64'(head_q.size()), 64'd5);
        chk("t3_tails", 64'(tail_q.size()), 64'd5);
        if (head_q.size() == 5 && tail_q.size() == 5)
            for (int i = 0; i < 4; i++) chk("t3_gap", 64'(head_q[i+1] - tail_q[i]), 64'd2);

        // Plan 4: ready dropped mid-packet; packet completes, next one waits.
        base = flits_out;
        send_pkt(6, 1'b1, 1'b1);
        wait_flits("t4_reach_flit2", base + 2, 100);
        man_rdy = 1'b0;
        send_pkt(3, 1'b1, 1'b1);
        repeat (20) step();
        chk("t4_held", 64'(flits_out - base), 64'd6);
        man_rdy = 1'b1;
        drain("t4", 100);
        chk("t4_total", 64'(flits_out - base), 64'd9);

        // Randomized traffic with random UM back-pressure.
        rand_on = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wait_src_ready("rand_src_ready");
            send_pkt(int'($urandom_range(2, 12)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        rand_on = 1'b0;
        man_rdy = 1'b1;
        drain("rand", 2000);
        chk("rand_no_ovf", 64'(ovf_err), 64'd0);

        // Plan 5: occupancy threshold on src_data_ready, then overflow.
        man_rdy = 1'b0;
        base = flits_out;
        send_pkt(160, 1'b1, 1'b1);
        repeat (3) step();
        chk("t5_ready_at_160", 64'(src_data_ready), 64'd1);
        write_flit(mk(HDR_HEAD), 1'b0, 1'b0);
        idle_in();
        repeat (3) step();
        chk("t5_ready_at_161", 64'(src_data_ready), 64'd0);
        for (int i = 0; i < 95; i++) write_flit(mk(HDR_BODY), 1'b0, 1'b0);
        idle_in();
        repeat (2) step();
        chk("t5_no_ovf_at_full", 64'(ovf_err), 64'd0);
        for (int i = 0; i < 3; i++) write_flit(mk(HDR_BODY), 1'b0, 1'b0);
        idle_in();
        repeat (2) step();
        chk("t5_ovf_set", 64'(ovf_err), 64'd1);
        man_rdy = 1'b1;
        wait_flits("t5_first_pkt_out", base + 160, 400);
        write_flit(mk(HDR_TAIL), 1'b1, 1'b1);
        idle_in();
        send_pkt(3, 1'b1, 1'b1);
        drain("t5", 600);
        repeat (10) step();
        chk("t5_total", 64'(flits_out - base), 64'd163);
        chk("t5_ovf_sticky", 64'(ovf_err), 64'd1);

        // Plan 6: reset during flit 3 of 8.
        base = flits_out;
        send_pkt(8, 1'b1, 1'b1);
        wait_flits("t6_reach_flit3", base + 3, 100);
        base_vwr = vwr_total;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr", 64'(pktin_data_wr), 64'd0);
        chk("t6_rst_valid_wr", 64'(pktin_data_valid_wr), 64'd0);
        chk("t6_rst_valid", 64'(pktin_data_valid), 64'd0);
        chk("t6_rst_data_zero", 64'(pktin_data == '0), 64'd1);
        chk("t6_rst_src_ready", 64'(src_data_ready), 64'd0);
        chk("t6_rst_ovf", 64'(ovf_err), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_ready_after_release", 64'(src_data_ready), 64'd1);
        base = flits_out;
        repeat (30) step();
        chk("t6_no_valid_wr", 64'(vwr_total - base_vwr), 64'd0);
        chk("t6_no_flits", 64'(flits_out - base), 64'd0);
        send_pkt(3, 1'b1, 1'b1);
        drain("t6", 100);
        chk("t6_post_reset_pkt", 64'(flits_out - base), 64'd3);
        chk("end_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
